// File: rtl/ctrl_pkg.sv
// Shared encodings for the mini RV64 main decoder: opcodes, function fields,
// ALU operation codes and the bundle of datapath strobes.
package ctrl_pkg;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    // funct3 values, instr[14:12]
    localparam logic [2:0] F3_LD      = 3'b011;
    localparam logic [2:0] F3_SD      = 3'b011;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;

    // funct7 values, instr[31:25]
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // ALU operation select driven into the datapath ALU
    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110
    } alu_ctrl_t;

    // Coarse instruction class derived from the opcode alone
    typedef enum logic [2:0] {
        CLS_OTHER  = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_RTYPE  = 3'd4
    } instr_class_t;

    // The six datapath strobes
    typedef struct packed {
        logic is_branch;
        logic mem_to_reg;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic alu_src;
    } ctrl_t;

endpackage

// File: rtl/control_alu_decoder.sv
// Secondary decoder: picks the ALU operation from the instruction class and
// the function fields, and reports whether an R-type combination is supported.
module alu_decoder
    import ctrl_pkg::*;
(
    input  instr_class_t cls,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    output alu_ctrl_t    alu_ctrl,
    output logic         rtype_legal
);

    // Memory ops compute an address with ADD, beq compares with SUB, and only
    // the four supported R-type funct7/funct3 pairs are flagged legal
    always_comb begin
        alu_ctrl    = ALU_ADD;
        rtype_legal = 1'b0;
        case (cls)
            CLS_BRANCH: alu_ctrl = ALU_SUB;
            CLS_RTYPE: begin
                case ({funct7, funct3})
                    {F7_BASE, F3_ADD_SUB}: begin alu_ctrl = ALU_ADD; rtype_legal = 1'b1; end
                    {F7_SUB,  F3_ADD_SUB}: begin alu_ctrl = ALU_SUB; rtype_legal = 1'b1; end
                    {F7_BASE, F3_AND}:     begin alu_ctrl = ALU_AND; rtype_legal = 1'b1; end
                    {F7_BASE, F3_OR}:      begin alu_ctrl = ALU_OR;  rtype_legal = 1'b1; end
                    default:               begin alu_ctrl = ALU_ADD; rtype_legal = 1'b0; end
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control.sv
// Main decoder of the single-cycle mini RV64 CPU. Decode is purely
// combinational; the clock only keeps a sticky record of illegal instructions.
module control
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    output logic        is_branch,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        alu_src,
    output logic [2:0]  alu_ctrl,
    output logic        illegal,
    output logic        illegal_seen
);

    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic [14:0]  unused_reg_fields;
    instr_class_t cls;
    alu_ctrl_t    alu_sel;
    logic         rtype_legal;
    logic         legal;
    ctrl_t        ctrl;
    ctrl_t        ctrl_out;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Register specifiers are routed to the register file elsewhere
    assign unused_reg_fields = {instr[24:15], instr[11:7]};

    // Classify by opcode; compressed encodings never match a full opcode
    always_comb begin
        cls = CLS_OTHER;
        case (opcode)
            OP_LOAD:   cls = CLS_LOAD;
            OP_STORE:  cls = CLS_STORE;
            OP_BRANCH: cls = CLS_BRANCH;
            OP_RTYPE:  cls = CLS_RTYPE;
            default:   cls = CLS_OTHER;
        endcase
    end

    alu_decoder u_alu_decoder (
        .cls         (cls),
        .funct3      (funct3),
        .funct7      (funct7),
        .alu_ctrl    (alu_sel),
        .rtype_legal (rtype_legal)
    );

    // Strobe pattern per class, plus the funct3 check that makes it legal
    always_comb begin
        ctrl  = '0;
        legal = 1'b0;
        case (cls)
            CLS_LOAD: begin
                legal           = (funct3 == F3_LD);
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_src    = 1'b1;
            end
            CLS_STORE: begin
                legal          = (funct3 == F3_SD);
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            CLS_BRANCH: begin
                legal          = (funct3 == F3_BEQ);
                ctrl.is_branch = 1'b1;
            end
            CLS_RTYPE: begin
                legal          = rtype_legal;
                ctrl.reg_write = 1'b1;
            end
            default: begin
                legal = 1'b0;
                ctrl  = '0;
            end
        endcase
    end

    // Unsupported instructions must have no side effects, so squash everything
    assign ctrl_out = legal ? ctrl : '0;
    assign illegal  = ~legal;

    assign is_branch  = ctrl_out.is_branch;
    assign mem_to_reg = ctrl_out.mem_to_reg;
    assign reg_write  = ctrl_out.reg_write;
    assign mem_read   = ctrl_out.mem_read;
    assign mem_write  = ctrl_out.mem_write;
    assign alu_src    = ctrl_out.alu_src;
    assign alu_ctrl   = legal ? alu_sel : ALU_ADD;

    // Sticky illegal flag; reset wins over an illegal decoded in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_seen <= 1'b0;
        end else begin
            illegal_seen <= illegal_seen | illegal;
        end
    end

endmodule

// File: tb/tb_control.sv
// Self-checking bench for the main decoder: directed vector table, hand-made
// sticky-flag sequences, and random instructions against a mask/match model.
module tb_control;

    typedef struct packed {
        logic       is_branch;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic [2:0] alu_ctrl;
        logic       illegal;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        exp_t        exp;
    } vec_t;

    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        exp_t        res;
    } pat_t;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        is_branch, mem_to_reg, reg_write, mem_read, mem_write, alu_src;
    logic [2:0]  alu_ctrl;
    logic        illegal, illegal_seen;

    int   total;
    int   bad;
    logic expSeen;
    pat_t pats[7];
    vec_t vecs[$];

    control dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .is_branch    (is_branch),
        .mem_to_reg   (mem_to_reg),
        .reg_write    (reg_write),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .alu_src      (alu_src),
        .alu_ctrl     (alu_ctrl),
        .illegal      (illegal),
        .illegal_seen (illegal_seen)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic br, m2r, rw, mr, mw, src,
                                input logic [2:0] alu, input logic ill);
        mk = {br, m2r, rw, mr, mw, src, alu, ill};
    endfunction

    // Reference: the supported set as mask/match patterns; anything else is illegal
    function automatic exp_t refModel(input logic [31:0] ins);
        refModel = mk(0, 0, 0, 0, 0, 0, 3'b010, 1);
        for (int p = 0; p < 7; p++) begin
            if ((ins & pats[p].mask) == pats[p].match) refModel = pats[p].res;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [9:0] got, input logic [9:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%b want=%b", name, got, want);
        end
    endtask

    // One cycle: drive at negedge, check decode, then check the sticky flag after posedge
    task automatic applyStimulus(input string name, input logic [31:0] ins,
                                 input logic rstVal, input exp_t want);
        @(negedge clk);
        instr = ins;
        rst   = rstVal;
        #1;
        checkOutput(name, {is_branch, mem_to_reg, reg_write, mem_read, mem_write,
                           alu_src, alu_ctrl, illegal}, want);
        @(posedge clk);
        expSeen = rstVal ? 1'b0 : (expSeen | want.illegal);
        #1;
        checkOutput({name, "_seen"}, {9'b0, illegal_seen}, {9'b0, expSeen});
    endtask

    initial begin
        exp_t ILL;
        logic [31:0] r;
        total   = 0;
        bad     = 0;
        expSeen = 1'b0;
        rst     = 1'b1;
        instr   = 32'h0;
        ILL     = mk(0, 0, 0, 0, 0, 0, 3'b010, 1);

        pats[0] = '{32'h0000707F, 32'h00003003, mk(0, 1, 1, 1, 0, 1, 3'b010, 0)}; // ld
        pats[1] = '{32'h0000707F, 32'h00003023, mk(0, 0, 0, 0, 1, 1, 3'b010, 0)}; // sd
        pats[2] = '{32'h0000707F, 32'h00000063, mk(1, 0, 0, 0, 0, 0, 3'b110, 0)}; // beq
        pats[3] = '{32'hFE00707F, 32'h00000033, mk(0, 0, 1, 0, 0, 0, 3'b010, 0)}; // add
        pats[4] = '{32'hFE00707F, 32'h40000033, mk(0, 0, 1, 0, 0, 0, 3'b110, 0)}; // sub
        pats[5] = '{32'hFE00707F, 32'h00007033, mk(0, 0, 1, 0, 0, 0, 3'b000, 0)}; // and
        pats[6] = '{32'hFE00707F, 32'h00006033, mk(0, 0, 1, 0, 0, 0, 3'b001, 0)}; // or

        vecs.push_back('{"beq",      32'h02208463, mk(1, 0, 0, 0, 0, 0, 3'b110, 0)});
        vecs.push_back('{"ld",       32'h02813083, mk(0, 1, 1, 1, 0, 1, 3'b010, 0)});
        vecs.push_back('{"sd",       32'h02113423, mk(0, 0, 0, 0, 1, 1, 3'b010, 0)});
        vecs.push_back('{"add",      32'h003100b3, mk(0, 0, 1, 0, 0, 0, 3'b010, 0)});
        vecs.push_back('{"sub",      32'h403100b3, mk(0, 0, 1, 0, 0, 0, 3'b110, 0)});
        vecs.push_back('{"and",      32'h003170b3, mk(0, 0, 1, 0, 0, 0, 3'b000, 0)});
        vecs.push_back('{"or",       32'h003160b3, mk(0, 0, 1, 0, 0, 0, 3'b001, 0)});
        vecs.push_back('{"lw",       32'h02812083, ILL});
        vecs.push_back('{"sw",       32'h02112423, ILL});
        vecs.push_back('{"bne",      32'h02209463, ILL});
        vecs.push_back('{"mul",      32'h023100b3, ILL});
        vecs.push_back('{"sub_f3",   32'h403170b3, ILL});
        vecs.push_back('{"xor",      32'h003140b3, ILL});
        vecs.push_back('{"compr_ld", 32'h02813080, ILL});
        vecs.push_back('{"zero",     32'h00000000, ILL});

        // Reset with a legal instruction, then the directed table under rst=1
        // so the flag stays clear while decode is still checked
        applyStimulus("reset", 32'h003100b3, 1'b1, mk(0, 0, 1, 0, 0, 0, 3'b010, 0));
        foreach (vecs[i]) applyStimulus(vecs[i].name, vecs[i].instr, 1'b1, vecs[i].exp);

        // Legal instructions out of reset leave the flag clear
        for (int i = 0; i < 7; i++) applyStimulus({"legal_", vecs[i].name}, vecs[i].instr, 1'b0, vecs[i].exp);

        // addi sets the sticky flag, which holds through legal instructions
        applyStimulus("addi",      32'h00000013, 1'b0, ILL);
        applyStimulus("hold_add",  32'h003100b3, 1'b0, mk(0, 0, 1, 0, 0, 0, 3'b010, 0));
        applyStimulus("hold_ld",   32'h02813083, 1'b0, mk(0, 1, 1, 1, 0, 1, 3'b010, 0));
        // One reset edge clears it, even with an illegal instruction present
        applyStimulus("rst_addi",  32'h00000013, 1'b1, ILL);
        applyStimulus("after_rst", 32'h02208463, 1'b0, mk(1, 0, 0, 0, 0, 0, 3'b110, 0));

        // Random mix: supported patterns with random don't-care bits, and raw words
        for (int i = 0; i < 300; i++) begin
            int p;
            r = $urandom;
            p = $urandom_range(0, 9);
            if (p < 7) r = (r & ~pats[p].mask) | pats[p].match;
            else if (p == 7) r = {r[31:7], 7'b0110011};
            applyStimulus("rand", r, ($urandom_range(0, 19) == 0), refModel(r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
